// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS instructions and writes them sequentially into instruction memory.
// Optional macro LOADER_HALT_WORD_EN: END stores an all-ones halt word before finishing.
module instr_encoder_loader #(
    parameter int NBITS     = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_Start,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [3:0]           i_OpKind,
    input  logic [4:0]           i_Rs,
    input  logic [4:0]           i_Rt,
    input  logic [4:0]           i_Rd,
    input  logic [15:0]          i_Imm,
    input  logic [25:0]          i_Target,
    output logic                 o_MemWrEn,
    output logic [ADDR_BITS-1:0] o_MemAddr,
    output logic [NBITS-1:0]     o_MemData,
    output logic [ADDR_BITS:0]   o_Count,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Error
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t           r_state;
    logic [5:0]       w_funct;
    logic [5:0]       w_op;
    logic [NBITS-1:0] w_word;
    logic             w_full;
    logic             w_end;
`ifdef LOADER_HALT_WORD_EN
    logic             r_halt;
`endif

    // The count saturates at DEPTH, so its MSB alone marks a full memory.
    assign w_full = o_Count[ADDR_BITS];
    assign w_end  = (i_OpKind == 4'd15);

    always_comb begin
        w_funct = 6'b100000;
        w_op    = 6'b000000;
        case (i_OpKind)
            4'd1:    w_funct = 6'b100010;
            4'd2:    w_funct = 6'b100011;
            4'd3:    w_funct = 6'b100100;
            4'd4:    w_funct = 6'b100101;
            4'd5:    w_funct = 6'b100111;
            4'd6:    w_funct = 6'b100110;
            4'd7:    w_funct = 6'b101010;
            4'd8:    w_op    = 6'b001000;
            4'd9:    w_op    = 6'b001100;
            4'd10:   w_op    = 6'b001010;
            4'd11:   w_op    = 6'b100011;
            4'd12:   w_op    = 6'b101011;
            4'd13:   w_op    = 6'b000100;
            default: ;
        endcase
        w_word = (i_OpKind < 4'd8)  ? {6'b000000, i_Rs, i_Rt, i_Rd, 5'b00000, w_funct} :
                 (i_OpKind == 4'd14) ? {6'b000010, i_Target} :
                                       {w_op, i_Rs, i_Rt, i_Imm};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            o_Ready   <= 1'b0;
            o_MemWrEn <= 1'b0;
            o_MemAddr <= '0;
            o_MemData <= '0;
            o_Count   <= '0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
`ifdef LOADER_HALT_WORD_EN
            r_halt    <= 1'b0;
`endif
        end else begin
            o_MemWrEn <= 1'b0;
            case (r_state)
                IDLE, DONE: if (i_Start) begin
                    r_state <= LOAD;
                    o_Ready <= 1'b1;
                    o_Busy  <= 1'b1;
                    o_Done  <= 1'b0;
                    o_Error <= 1'b0;
                    o_Count <= '0;
                end
                LOAD: if (i_Valid && o_Ready) begin
                    o_Ready <= 1'b0;
                    if (!w_end && !w_full) begin
                        r_state   <= WRITE;
                        o_MemWrEn <= 1'b1;
                        o_MemAddr <= o_Count[ADDR_BITS-1:0];
                        o_MemData <= w_word;
                    end
`ifdef LOADER_HALT_WORD_EN
                    else if (!w_full) begin
                        r_state   <= WRITE;
                        o_MemWrEn <= 1'b1;
                        o_MemAddr <= o_Count[ADDR_BITS-1:0];
                        o_MemData <= '1;
                        r_halt    <= 1'b1;
                    end
`endif
                    else begin
                        r_state <= DONE;
                        o_Busy  <= 1'b0;
                        o_Done  <= 1'b1;
                        o_Error <= !w_end;
                    end
                end
                WRITE: begin
                    o_Count <= o_Count + (ADDR_BITS+1)'(1);
`ifdef LOADER_HALT_WORD_EN
                    if (r_halt) begin
                        r_state <= DONE;
                        r_halt  <= 1'b0;
                        o_Busy  <= 1'b0;
                        o_Done  <= 1'b1;
                    end else begin
                        r_state <= LOAD;
                        o_Ready <= 1'b1;
                    end
`else
                    r_state <= LOAD;
                    o_Ready <= 1'b1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed scoreboard bench for instr_encoder_loader (default and ADDR_BITS=2 instances).
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, valid_a, valid_b;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    logic        rdy_a, wr_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] data_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, wr_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.NBITS(32), .ADDR_BITS(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_Start(start_a), .i_Valid(valid_a), .o_Ready(rdy_a),
        .i_OpKind(kind), .i_Rs(rs), .i_Rt(rt), .i_Rd(rd), .i_Imm(imm), .i_Target(tgt),
        .o_MemWrEn(wr_a), .o_MemAddr(addr_a), .o_MemData(data_a), .o_Count(cnt_a),
        .o_Busy(busy_a), .o_Done(done_a), .o_Error(err_a));

    instr_encoder_loader #(.NBITS(32), .ADDR_BITS(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_Start(start_b), .i_Valid(valid_b), .o_Ready(rdy_b),
        .i_OpKind(kind), .i_Rs(rs), .i_Rt(rt), .i_Rd(rd), .i_Imm(imm), .i_Target(tgt),
        .o_MemWrEn(wr_b), .o_MemAddr(addr_b), .o_MemData(data_b), .o_Count(cnt_b),
        .o_Busy(busy_b), .o_Done(done_b), .o_Error(err_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each memory strobe is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_a) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_strobe_a: observed addr=%0h data=%0h expected no write", addr_a, data_a);
            end else chk("write_a", {32'(addr_a), data_a}, qa.pop_front());
            chk("ready_low_in_write_a", 64'(rdy_a), 64'(0));
            chk("single_strobe_a", 64'(prev_a), 64'(0));
        end
        if (wr_b) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_strobe_b: observed addr=%0h data=%0h expected no write", addr_b, data_b);
            end else chk("write_b", {32'(addr_b), data_b}, qb.pop_front());
            chk("single_strobe_b", 64'(prev_b), 64'(0));
        end
        prev_a <= wr_a;
        prev_b <= wr_b;
    end

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input bit b, input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
        int n = 0;
        kind = k; rs = s; rt = t; rd = d; imm = im; tgt = tg;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        while (!(b ? rdy_b : rdy_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $error("FAIL ready_timeout: observed ready=0 for %0d cycles expected ready=1", n);
            valid_a = 1'b0;
            valid_b = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            valid_a = 1'b0;
            valid_b = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        kind = 4'd0; rs = '0; rt = '0; rd = '0; imm = '0; tgt = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs_a", {rdy_a, wr_a, addr_a, data_a, cnt_a, busy_a, done_a, err_a}, 64'(0));
        chk("reset_outputs_b", {rdy_b, wr_b, addr_b, data_b, cnt_b, busy_b, done_b, err_b}, 64'(0));
        rst_n = 1'b1;

        valid_a = 1'b1;
        repeat (2) @(negedge clk);
        valid_a = 1'b0;
        chk("idle_ignores_valid", {rdy_a, cnt_a}, 64'(0));

        pulse_start(1'b0);
        chk("load_entry", {rdy_a, busy_a, done_a}, 64'b110);

        qa.push_back({32'd0, 32'h00221820}); push(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        chk("count_after_first", {cnt_a, rdy_a}, {9'd1, 1'b1});
        qa.push_back({32'd1, 32'h2005FFFF}); push(1'b0, 4'd8, 5'd0, 5'd5, 5'd0, 16'hFFFF, 26'h0);
        qa.push_back({32'd2, 32'h8C860008}); push(1'b0, 4'd11, 5'd4, 5'd6, 5'd0, 16'h0008, 26'h0);
        @(negedge clk);
        pulse_start(1'b0);
        chk("start_ignored_in_load", {cnt_a, busy_a}, {9'd3, 1'b1});
        qa.push_back({32'd3, 32'h03E0F822}); push(1'b0, 4'd1, 5'd31, 5'd0, 5'd31, 16'h0, 26'h0);
        qa.push_back({32'd4, 32'hAC430004}); push(1'b0, 4'd12, 5'd2, 5'd3, 5'd0, 16'h0004, 26'h0);
        qa.push_back({32'd5, 32'h00000827}); push(1'b0, 4'd5, 5'd0, 5'd0, 5'd1, 16'h0, 26'h0);
        qa.push_back({32'd6, 32'h28218000}); push(1'b0, 4'd10, 5'd1, 5'd1, 5'd0, 16'h8000, 26'h0);
        qa.push_back({32'd7, 32'h1022FFFE}); push(1'b0, 4'd13, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0);
        qa.push_back({32'd8, 32'h08000010}); push(1'b0, 4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
`ifdef LOADER_HALT_WORD_EN
        qa.push_back({32'd9, 32'hFFFFFFFF}); push(1'b0, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        @(negedge clk);
        chk("done_state", {done_a, busy_a, rdy_a, err_a, cnt_a}, {4'b1000, 9'd10});
        chk("held_mem_outputs", {32'(addr_a), data_a}, {32'd9, 32'hFFFFFFFF});
`else
        push(1'b0, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("done_state", {done_a, busy_a, rdy_a, err_a, cnt_a}, {4'b1000, 9'd9});
        chk("held_mem_outputs", {32'(addr_a), data_a}, {32'd8, 32'h08000010});
`endif
        valid_a = 1'b1;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        chk("done_ignores_valid", {rdy_a, done_a}, 64'b01);

        pulse_start(1'b0);
        chk("restart_clears", {cnt_a, done_a, err_a, busy_a}, {9'd0, 3'b001});
        qa.push_back({32'd0, 32'h00221820}); push(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        #2 rst_n = 1'b0;
        #1 chk("reset_in_write", {rdy_a, wr_a, addr_a, data_a, cnt_a, busy_a, done_a, err_a}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        valid_a = 1'b1;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        chk("no_start_after_reset", {rdy_a, cnt_a}, 64'(0));

        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            qb.push_back({32'(i), 32'h00220020 | (32'(i) << 11)});
            push(1'b1, 4'd0, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0);
            @(negedge clk);
        end
        push(1'b1, 4'd0, 5'd1, 5'd2, 5'd9, 16'h0, 26'h0);
        @(negedge clk);
        chk("overflow_state", {err_b, done_b, busy_b, rdy_b, cnt_b}, {4'b1100, 3'd4});
        pulse_start(1'b1);
        chk("restart_clears_error", {err_b, done_b, cnt_b}, 64'(0));

        @(negedge clk);
        chk("queue_a_drained", 64'(qa.size()), 64'(0));
        chk("queue_b_drained", 64'(qb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
